// File: rtl/audio_out_serializer.sv
// Codec DAC output path: per-channel sample FIFOs feeding an MSB-first
// serializer that is framed by LRCK edges and clocked out on BCLK falls.

module audio_out_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic [7:0]   used
);
    logic [W-1:0] mem [128];
    logic [6:0]   wr_ptr, rd_ptr;
    logic [7:0]   count;
    logic         full, wr_en, rd_en;

    assign full  = (count == 8'd128);
    assign empty = (count == 8'd0);
    assign used  = count;
    assign dout  = mem[rd_ptr];

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 7'd1;
            if (rd_en) rd_ptr <= rd_ptr + 7'd1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 8'd1;
                2'b01:   count <= count - 8'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

module audio_out_serializer #(
    parameter int AUDIO_DATA_WIDTH = 16,
    parameter int FIFO_DEPTH       = 128  // only 128 is supported (7-bit pointers)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bit_clk_rising_edge,
    input  logic                        bit_clk_falling_edge,
    input  logic                        left_right_clk_rising_edge,
    input  logic                        left_right_clk_falling_edge,
    input  logic                        done_channel_sync,
    input  logic [AUDIO_DATA_WIDTH-1:0] left_channel_data,
    input  logic [AUDIO_DATA_WIDTH-1:0] right_channel_data,
    input  logic                        write_left_audio_data_en,
    input  logic                        write_right_audio_data_en,
    output logic [7:0]                  left_channel_fifo_write_space,
    output logic [7:0]                  right_channel_fifo_write_space,
    output logic                        serial_audio_out_data
);
    localparam int W   = AUDIO_DATA_WIDTH;
    localparam int NCH = 2;
    localparam int CW  = $clog2(W + 1);

    // Channel 0 is left, channel 1 is right.
    logic [NCH-1:0]        push, pop, empty;
    logic [NCH-1:0][W-1:0] din, dout;
    logic [NCH-1:0][7:0]   used;

    logic [W-1:0]  shift_reg;
    logic [CW-1:0] bit_cnt;

    // BCLK rising edge carries no state; it exists for interface symmetry.
    logic unused_bit_clk_rise;
    assign unused_bit_clk_rise = bit_clk_rising_edge;

    assign push = {write_right_audio_data_en, write_left_audio_data_en};
    assign din  = {right_channel_data, left_channel_data};

    assign pop[0] = left_right_clk_rising_edge  & done_channel_sync & ~empty[0];
    assign pop[1] = left_right_clk_falling_edge & done_channel_sync & ~empty[1];

    generate
        for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
            audio_out_fifo #(.W(W)) u_fifo (
                .clk   (clk),
                .reset (reset),
                .push  (push[ch]),
                .pop   (pop[ch]),
                .din   (din[ch]),
                .dout  (dout[ch]),
                .empty (empty[ch]),
                .used  (used[ch])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_channel_fifo_write_space  <= 8'd0;
            right_channel_fifo_write_space <= 8'd0;
        end else begin
            left_channel_fifo_write_space  <= 8'd128 - used[0];
            right_channel_fifo_write_space <= 8'd128 - used[1];
        end
    end

    // LRCK edges win over BCLK: a new slot aborts any word still in flight,
    // and an empty FIFO yields a silent (all-zero) slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (!done_channel_sync) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (left_right_clk_rising_edge) begin
            shift_reg <= pop[0] ? dout[0] : '0;
            bit_cnt   <= CW'(W);
        end else if (left_right_clk_falling_edge) begin
            shift_reg <= pop[1] ? dout[1] : '0;
            bit_cnt   <= CW'(W);
        end else if (bit_clk_falling_edge && bit_cnt != '0) begin
            shift_reg <= {shift_reg[W-2:0], 1'b0};
            bit_cnt   <= bit_cnt - CW'(1);
        end
    end

    assign serial_audio_out_data = shift_reg[W-1];
endmodule

// File: tb/tb_audio_out_serializer.sv
// Directed bench for audio_out_serializer: queue-based model checked every
// cycle, plus literal expectations on framing, overflow and reset behaviour.

module tb_audio_out_serializer;
    logic        clk = 0;
    logic        reset = 0;
    logic        bclk_rise = 0, bclk_fall = 0, lr_rise_s = 0, lr_fall_s = 0;
    logic        sync = 0;
    logic [15:0] ldata = 0, rdata = 0;
    logic        wl = 0, wr = 0;
    logic [7:0]  space_l, space_r;
    logic        serial;

    int n_tests = 0;
    int n_fail  = 0;

    audio_out_serializer dut (
        .clk                            (clk),
        .reset                          (reset),
        .bit_clk_rising_edge            (bclk_rise),
        .bit_clk_falling_edge           (bclk_fall),
        .left_right_clk_rising_edge     (lr_rise_s),
        .left_right_clk_falling_edge    (lr_fall_s),
        .done_channel_sync              (sync),
        .left_channel_data              (ldata),
        .right_channel_data             (rdata),
        .write_left_audio_data_en       (wl),
        .write_right_audio_data_en      (wr),
        .left_channel_fifo_write_space  (space_l),
        .right_channel_fifo_write_space (space_r),
        .serial_audio_out_data          (serial)
    );

    always #10 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: queues for the FIFOs, the current slot word and bits still to send.
    logic [15:0] lq[$], rq[$];
    logic [15:0] m_word = 0, lw, rw;
    int          m_bits = 0;
    logic [7:0]  m_space_l = 0, m_space_r = 0;
    int          ls, rs;
    logic        pl, pr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            lq.delete(); rq.delete();
            m_space_l = 0; m_space_r = 0; m_bits = 0; m_word = 0;
        end else begin
            ls = lq.size(); rs = rq.size();
            m_space_l = 8'(128 - ls);
            m_space_r = 8'(128 - rs);
            pl = lr_rise_s && sync && ls > 0;
            pr = lr_fall_s && sync && rs > 0;
            lw = 0; rw = 0;
            if (pl) lw = lq.pop_front();
            if (pr) rw = rq.pop_front();
            if (wl && (ls < 128 || pl)) lq.push_back(ldata);
            if (wr && (rs < 128 || pr)) rq.push_back(rdata);
            if (!sync) begin m_bits = 0; m_word = 0; end
            else if (lr_rise_s) begin m_word = lw; m_bits = 16; end
            else if (lr_fall_s) begin m_word = rw; m_bits = 16; end
            else if (bclk_fall && m_bits > 0) m_bits--;
        end
    end

    always @(negedge clk) begin
        check("serial_model", {31'd0, serial}, {31'd0, (m_bits > 0) ? m_word[m_bits-1] : 1'b0});
        check("space_l_model", {24'd0, space_l}, {24'd0, m_space_l});
        check("space_r_model", {24'd0, space_r}, {24'd0, m_space_r});
    end

    task automatic idle(input int n); repeat (n) @(negedge clk); endtask
    task automatic push_l(input logic [15:0] d); wl = 1; ldata = d; @(negedge clk); wl = 0; endtask
    task automatic push_r(input logic [15:0] d); wr = 1; rdata = d; @(negedge clk); wr = 0; endtask
    task automatic lr_rise(); lr_rise_s = 1; @(negedge clk); lr_rise_s = 0; endtask
    task automatic lr_fall(); lr_fall_s = 1; @(negedge clk); lr_fall_s = 0; endtask
    task automatic bfall(); bclk_fall = 1; @(negedge clk); bclk_fall = 0; endtask
    task automatic get_word(output logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            w[15-i] = serial;
            bfall();
            bclk_rise = 1; @(negedge clk); bclk_rise = 0;
        end
    endtask

    logic [15:0] w;

    initial begin
        @(negedge clk);
        check("reset_space_l", {24'd0, space_l}, 32'd0);
        check("reset_serial", {31'd0, serial}, 32'd0);
        #3 reset = 1;
        idle(2);
        check("idle_space_l", {24'd0, space_l}, 32'd128);
        check("idle_space_r", {24'd0, space_r}, 32'd128);
        check("idle_serial", {31'd0, serial}, 32'd0);

        // Basic left/right frame
        push_l(16'hA5C3);
        push_r(16'h1234);
        sync = 1;
        idle(1);
        check("pushed_space_l", {24'd0, space_l}, 32'd127);
        lr_rise();
        get_word(w);
        check("left_word", {16'd0, w}, 32'hA5C3);
        check("left_tail_zero", {31'd0, serial}, 32'd0);
        lr_fall();
        get_word(w);
        check("right_word", {16'd0, w}, 32'h1234);
        check("right_tail_zero", {31'd0, serial}, 32'd0);
        idle(1);
        check("drained_space_l", {24'd0, space_l}, 32'd128);
        check("drained_space_r", {24'd0, space_r}, 32'd128);

        // Underflow slots are silent
        lr_rise();
        check("uf_left_serial", {31'd0, serial}, 32'd0);
        bfall();
        lr_fall();
        check("uf_right_serial", {31'd0, serial}, 32'd0);
        idle(1);
        check("uf_space_l", {24'd0, space_l}, 32'd128);

        // Losing sync mid-word clears the output
        push_l(16'hFFFF);
        lr_rise();
        bfall(); bfall();
        check("sync_pre_serial", {31'd0, serial}, 32'd1);
        sync = 0;
        idle(1);
        check("sync_lost_serial", {31'd0, serial}, 32'd0);
        sync = 1;
        idle(1);

        // Overflow: 130 pushes, last two dropped
        for (int i = 1; i <= 130; i++) push_l(16'(i));
        check("full_space_l", {24'd0, space_l}, 32'd0);
        check("full_space_r", {24'd0, space_r}, 32'd128);
        for (int i = 1; i <= 128; i++) begin
            lr_rise();
            get_word(w);
            check("ordered_word", {16'd0, w}, i);
            lr_fall();
        end
        lr_rise();
        get_word(w);
        check("dropped_word_absent", {16'd0, w}, 32'd0);
        check("after_drain_space_l", {24'd0, space_l}, 32'd128);

        // Full FIFO: push and pop in the same cycle
        for (int i = 0; i < 128; i++) push_l(16'hFF00 + 16'(i));
        wl = 1; ldata = 16'hBEEF; lr_rise_s = 1;
        @(negedge clk);
        wl = 0; lr_rise_s = 0;
        check("pushpop_space_l_0", {24'd0, space_l}, 32'd0);
        idle(1);
        check("pushpop_space_l_1", {24'd0, space_l}, 32'd0);
        get_word(w);
        check("pushpop_word", {16'd0, w}, 32'hFF00);

        // Asynchronous reset mid-word after 5 shifted bits (word 0xFF01, bit 10 = 1)
        lr_rise();
        repeat (5) bfall();
        check("mid_word_serial", {31'd0, serial}, 32'd1);
        #2 reset = 0;
        #1;
        check("async_rst_serial", {31'd0, serial}, 32'd0);
        check("async_rst_space_l", {24'd0, space_l}, 32'd0);
        check("async_rst_space_r", {24'd0, space_r}, 32'd0);
        @(negedge clk);
        #3 reset = 1;
        @(negedge clk);
        check("release_space_l", {24'd0, space_l}, 32'd128);
        check("release_space_r", {24'd0, space_r}, 32'd128);
        check("release_serial", {31'd0, serial}, 32'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
